// File: rtl/l2_flush_seq_pkg.sv
// l2_flush_seq_pkg
//   Shared constants and types for the L2 flush sequencer:
//   - L2 line-state encodings (I/V/O/S) as returned by the tag/state SRAM.
//   - Flush FSM state enumeration.
//   - Width helpers used to derive SET_BITS, WAY_BITS and CNT_BITS from the
//     geometry parameters.
package l2_flush_seq_pkg;

   typedef enum logic [1:0] {
      LS_I = 2'd0,
      LS_V = 2'd1,
      LS_O = 2'd2,
      LS_S = 2'd3
   } line_state_e;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_RD    = 3'd1,
      FS_CHK   = 3'd2,
      FS_ACT   = 3'd3,
      FS_DRAIN = 3'd4,
      FS_DONE  = 3'd5
   } flush_state_e;

   localparam int unsigned L2_SETS_DEF  = 256;
   localparam int unsigned L2_WAYS_DEF  = 8;
   localparam int unsigned TAG_BITS_DEF = 20;
   localparam int unsigned N_WB_DEF     = 4;

   // Index width for a power-of-two count (sets or ways).
   function automatic int unsigned log2_f(input int unsigned n);
      return $clog2(n);
   endfunction

   // Counter width able to hold 0..n_wb inclusive.
   function automatic int unsigned cnt_bits_f(input int unsigned n_wb);
      return $clog2(n_wb) + 1;
   endfunction

endpackage

// File: rtl/l2_flush_seq_if.sv
// l2_flush_seq_if
//   Bundle of every non-clock/reset signal of the flush sequencer.
//   master : sequencer side (drives control, tag-array read, invalidate,
//            writeback request and status).
//   slave  : environment side (arbiter flush_start, tag/state SRAM read
//            data, LLC writeback ready/ack).
//   Signals: flush_start, flush_busy, flush_done, cur_set, cur_way,
//            tag_rd_en, tag_rd_state, tag_rd_tag, inv_en, wb_valid,
//            wb_ready, wb_addr, wb_ack, wb_outstanding, ack_underflow.
interface l2_flush_seq_if
   import l2_flush_seq_pkg::*;
#(
   parameter int unsigned L2_SETS  = L2_SETS_DEF,
   parameter int unsigned L2_WAYS  = L2_WAYS_DEF,
   parameter int unsigned TAG_BITS = TAG_BITS_DEF,
   parameter int unsigned N_WB     = N_WB_DEF
) ();

   localparam int unsigned SET_BITS = log2_f(L2_SETS);
   localparam int unsigned WAY_BITS = log2_f(L2_WAYS);
   localparam int unsigned CNT_BITS = cnt_bits_f(N_WB);

   logic                         flush_start;
   logic                         flush_busy;
   logic                         flush_done;
   logic [SET_BITS-1:0]          cur_set;
   logic [WAY_BITS-1:0]          cur_way;
   logic                         tag_rd_en;
   logic [1:0]                   tag_rd_state;
   logic [TAG_BITS-1:0]          tag_rd_tag;
   logic                         inv_en;
   logic                         wb_valid;
   logic                         wb_ready;
   logic [TAG_BITS+SET_BITS-1:0] wb_addr;
   logic                         wb_ack;
   logic [CNT_BITS-1:0]          wb_outstanding;
   logic                         ack_underflow;

   modport master (
      input  flush_start, tag_rd_state, tag_rd_tag, wb_ready, wb_ack,
      output flush_busy, flush_done, cur_set, cur_way, tag_rd_en, inv_en,
             wb_valid, wb_addr, wb_outstanding, ack_underflow
   );

   modport slave (
      output flush_start, tag_rd_state, tag_rd_tag, wb_ready, wb_ack,
      input  flush_busy, flush_done, cur_set, cur_way, tag_rd_en, inv_en,
             wb_valid, wb_addr, wb_outstanding, ack_underflow
   );

endinterface

// File: rtl/l2_flush_wb_cnt.sv
// l2_flush_wb_cnt
//   Outstanding-writeback up/down counter.
//   Ports:
//     clk, rst     : clock, asynchronous active-low reset
//     inc_i        : writeback handshake this cycle
//     dec_i        : writeback ack from LLC this cycle
//     cnt_o        : writebacks in flight (0..N_WB)
//     underflow_o  : sticky flag, set by an ack arriving with nothing in
//                    flight; cleared only by reset
module l2_flush_wb_cnt
   import l2_flush_seq_pkg::*;
#(
   parameter int unsigned N_WB     = N_WB_DEF,
   parameter int unsigned CNT_BITS = cnt_bits_f(N_WB)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc_i,
   input  logic                dec_i,
   output logic [CNT_BITS-1:0] cnt_o,
   output logic                underflow_o
);

   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(N_WB);

   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                uf_q, uf_d;

   always_comb begin
      cnt_d = cnt_q;
      uf_d  = uf_q;
      case ({inc_i, dec_i})
         2'b10: begin
            // Guard only; the request side is already gated at CNT_MAX.
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_BITS'(1);
         end
         2'b01: begin
            if (cnt_q == '0) uf_d = 1'b1;
            else             cnt_d = cnt_q - CNT_BITS'(1);
         end
         default: ;  // idle, or inc and dec cancel
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         uf_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         uf_q  <= uf_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign underflow_o = uf_q;

endmodule

// File: rtl/l2_flush_seq.sv
// l2_flush_seq
//   Full-L2 flush sequencer. Walks every (set, way) in order; for each
//   line reads tag/state (RD), captures the read data (CHK), then acts
//   (ACT): Owned lines are written back to the LLC and invalidated, V/S
//   lines are invalidated, I lines are skipped. After the last line it
//   waits for all writebacks to be acknowledged (DRAIN) and pulses
//   flush_done (DONE).
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset
//     bus  : l2_flush_seq_if.master (flush control, tag read, invalidate,
//            writeback request/ack and status signals)
module l2_flush_seq
   import l2_flush_seq_pkg::*;
#(
   parameter int unsigned L2_SETS  = L2_SETS_DEF,
   parameter int unsigned L2_WAYS  = L2_WAYS_DEF,
   parameter int unsigned TAG_BITS = TAG_BITS_DEF,
   parameter int unsigned N_WB     = N_WB_DEF
) (
   input  logic           clk,
   input  logic           rst,
   l2_flush_seq_if.master bus
);

   localparam int unsigned SET_BITS = log2_f(L2_SETS);
   localparam int unsigned WAY_BITS = log2_f(L2_WAYS);
   localparam int unsigned CNT_BITS = cnt_bits_f(N_WB);

   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(L2_SETS - 1);
   localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(L2_WAYS - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(N_WB);

   flush_state_e        state_q;
   logic [SET_BITS-1:0] set_q, set_d;
   logic [WAY_BITS-1:0] way_q, way_d;
   line_state_e         st_q;
   logic [TAG_BITS-1:0] tag_q;

   logic                wb_valid;
   logic                wb_hs;
   logic                inv_en;
   logic                act_done;
   logic                last_way;
   logic                last_set;
   logic [CNT_BITS-1:0] wb_cnt;
   logic                ack_uf;

   // Writeback request is held off while the LLC window is full. Since the
   // counter can only drop while ACT stalls, a raised wb_valid stays high
   // until accepted.
   assign wb_valid = (state_q == FS_ACT) && (st_q == LS_O) && (wb_cnt < CNT_MAX);
   assign wb_hs    = wb_valid && bus.wb_ready;

   always_comb begin
      act_done = 1'b0;
      inv_en   = 1'b0;
      if (state_q == FS_ACT) begin
         case (st_q)
            LS_I: act_done = 1'b1;
            LS_V,
            LS_S: begin
               act_done = 1'b1;
               inv_en   = 1'b1;
            end
            LS_O: begin
               // Invalidate in the same cycle the writeback is accepted.
               act_done = wb_hs;
               inv_en   = wb_hs;
            end
            default: ;
         endcase
      end
   end

   // Walker next position; unused on the final line, where the end test wins.
   assign last_way = (way_q == LAST_WAY);
   assign last_set = (set_q == LAST_SET);

   always_comb begin
      set_d = set_q;
      way_d = way_q + WAY_BITS'(1);
      if (last_way) begin
         way_d = '0;
         set_d = set_q + SET_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FS_IDLE;
         set_q   <= '0;
         way_q   <= '0;
      end else begin
         case (state_q)
            FS_IDLE: begin
               if (bus.flush_start) begin
                  state_q <= FS_RD;
                  set_q   <= '0;
                  way_q   <= '0;
               end
            end
            FS_RD:  state_q <= FS_CHK;
            FS_CHK: state_q <= FS_ACT;
            FS_ACT: begin
               if (act_done) begin
                  if (last_way && last_set) begin
                     state_q <= FS_DRAIN;
                  end else begin
                     set_q   <= set_d;
                     way_q   <= way_d;
                     state_q <= FS_RD;
                  end
               end
            end
            FS_DRAIN: begin
               if (wb_cnt == '0) state_q <= FS_DONE;
            end
            FS_DONE: state_q <= FS_IDLE;
            default: state_q <= FS_IDLE;
         endcase
      end
   end

   // Tag/state read data lands the cycle after RD.
   always_ff @(posedge clk) begin
      if (state_q == FS_CHK) begin
         st_q  <= line_state_e'(bus.tag_rd_state);
         tag_q <= bus.tag_rd_tag;
      end
   end

   l2_flush_wb_cnt #(
      .N_WB     (N_WB),
      .CNT_BITS (CNT_BITS)
   ) u_wb_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (wb_hs),
      .dec_i       (bus.wb_ack),
      .cnt_o       (wb_cnt),
      .underflow_o (ack_uf)
   );

   assign bus.flush_busy     = (state_q != FS_IDLE);
   assign bus.flush_done     = (state_q == FS_DONE);
   assign bus.tag_rd_en      = (state_q == FS_RD);
   assign bus.cur_set        = set_q;
   assign bus.cur_way        = way_q;
   assign bus.inv_en         = inv_en;
   assign bus.wb_valid       = wb_valid;
   // Captured tag is not reset, so the address is zeroed when idle.
   assign bus.wb_addr        = wb_valid ? {tag_q, set_q} : '0;
   assign bus.wb_outstanding = wb_cnt;
   assign bus.ack_underflow  = ack_uf;

endmodule

// File: tb/tb_l2_flush_seq.sv
// tb_l2_flush_seq
//   Directed bench for l2_flush_seq with a 4-set x 2-way cache, 20-bit
//   tags and a 4-deep writeback window. A table of whole-cache fill
//   patterns is flushed and counted; hand-written sequences cover the
//   writeback path, window-full stall, ready back-pressure, simultaneous
//   handshake/ack, ack underflow, ignored restart and mid-flush reset.
module tb_l2_flush_seq;
   import l2_flush_seq_pkg::*;

   localparam int unsigned SETS = 4;
   localparam int unsigned WAYS = 2;
   localparam int unsigned TAGW = 20;
   localparam int unsigned NWB  = 4;
   localparam int unsigned SB   = 2;
   localparam int unsigned AW   = TAGW + SB;
   localparam int LAT           = 26;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   l2_flush_seq_if #(.L2_SETS(SETS), .L2_WAYS(WAYS), .TAG_BITS(TAGW), .N_WB(NWB)) bus ();

   l2_flush_seq #(.L2_SETS(SETS), .L2_WAYS(WAYS), .TAG_BITS(TAGW), .N_WB(NWB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Tag/state array model, indexed by {set, way}.
   logic [1:0]      mem_st  [0:7];
   logic [TAGW-1:0] mem_tag [0:7];

   always_comb begin
      bus.tag_rd_state = mem_st[{bus.cur_set, bus.cur_way}];
      bus.tag_rd_tag   = mem_tag[{bus.cur_set, bus.cur_way}];
   end

   int total = 0;
   int bad   = 0;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Event monitor, sampled mid-cycle.
   int            n_rd = 0, n_inv = 0, n_hs = 0, n_done = 0, done_cyc = 0;
   logic [AW-1:0] last_addr = '0;
   logic          last_hs_inv = 1'b0;
   always @(negedge clk) begin
      if (bus.tag_rd_en) n_rd++;
      if (bus.inv_en) n_inv++;
      if (bus.wb_valid && bus.wb_ready) begin
         n_hs++;
         last_addr   = bus.wb_addr;
         last_hs_inv = bus.inv_en;
      end
      if (bus.flush_done) begin
         n_done++;
         done_cyc = cyc_n;
      end
   end

   typedef struct {
      logic [1:0] fill;
      int         sp_idx;
      logic [1:0] sp_st;
      int         sp2_idx;
      logic [1:0] sp2_st;
      int         e_rd;
      int         e_inv;
      int         e_hs;
      int         e_lat;
   } vec_t;

   vec_t tv [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc();
   endtask

   task automatic load(input logic [1:0] st_all);
      for (int i = 0; i < 8; i++) begin
         mem_st[i]  = st_all;
         mem_tag[i] = TAGW'(32'h100 + i);
      end
   endtask

   task automatic start_flush(output int sc);
      cyc();
      bus.flush_start = 1'b1;
      sc = cyc_n;
      cyc();
      bus.flush_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int lim);
      int base;
      base = n_done;
      for (int i = 0; i < lim; i++) begin
         if (n_done != base) break;
         cyc();
      end
      total++;
      if (n_done == base) begin
         bad++;
         $display("FAIL %s: flush_done not seen within %0d cycles", name, lim);
      end
   endtask

   // Return acks only while something is in flight, until flush_done.
   task automatic acks_until_done(input string name, input int lim);
      int base;
      base = n_done;
      for (int i = 0; i < lim; i++) begin
         bus.wb_ack = (bus.wb_outstanding != '0);
         cyc();
         if (n_done != base) break;
      end
      bus.wb_ack = 1'b0;
      total++;
      if (n_done == base) begin
         bad++;
         $display("FAIL %s: flush_done not seen within %0d cycles", name, lim);
      end
   endtask

   int sc, b_rd, b_inv, b_hs, b_done;

   task automatic snap();
      b_rd   = n_rd;
      b_inv  = n_inv;
      b_hs   = n_hs;
      b_done = n_done;
   endtask

   initial begin
      bus.flush_start = 1'b0;
      bus.wb_ready    = 1'b0;
      bus.wb_ack      = 1'b0;
      load(LS_I);

      tv[0] = '{fill:LS_I, sp_idx:-1, sp_st:LS_I, sp2_idx:-1, sp2_st:LS_I, e_rd:8, e_inv:0, e_hs:0, e_lat:LAT};
      tv[1] = '{fill:LS_V, sp_idx:-1, sp_st:LS_I, sp2_idx:-1, sp2_st:LS_I, e_rd:8, e_inv:8, e_hs:0, e_lat:LAT};
      tv[2] = '{fill:LS_S, sp_idx:-1, sp_st:LS_I, sp2_idx:-1, sp2_st:LS_I, e_rd:8, e_inv:8, e_hs:0, e_lat:LAT};
      tv[3] = '{fill:LS_I, sp_idx:5,  sp_st:LS_V, sp2_idx:-1, sp2_st:LS_I, e_rd:8, e_inv:1, e_hs:0, e_lat:LAT};
      tv[4] = '{fill:LS_I, sp_idx:0,  sp_st:LS_S, sp2_idx:7,  sp2_st:LS_V, e_rd:8, e_inv:2, e_hs:0, e_lat:LAT};

      // Reset state
      #2 rst = 1'b0;
      cycles(3);
      check("rst_busy", bus.flush_busy, 0);
      check("rst_done", bus.flush_done, 0);
      check("rst_set", bus.cur_set, 0);
      check("rst_way", bus.cur_way, 0);
      check("rst_rd_en", bus.tag_rd_en, 0);
      check("rst_inv", bus.inv_en, 0);
      check("rst_wbv", bus.wb_valid, 0);
      check("rst_addr", bus.wb_addr, 0);
      check("rst_out", bus.wb_outstanding, 0);
      check("rst_uf", bus.ack_underflow, 0);
      rst = 1'b1;
      cycles(2);

      // Table: fill patterns with no writebacks
      for (int t = 0; t < 5; t++) begin
         load(tv[t].fill);
         if (tv[t].sp_idx >= 0)  mem_st[tv[t].sp_idx]  = tv[t].sp_st;
         if (tv[t].sp2_idx >= 0) mem_st[tv[t].sp2_idx] = tv[t].sp2_st;
         snap();
         start_flush(sc);
         check($sformatf("tbl%0d_busy", t), bus.flush_busy, 1);
         wait_done($sformatf("tbl%0d_done", t), 40);
         check($sformatf("tbl%0d_rd", t), n_rd - b_rd, tv[t].e_rd);
         check($sformatf("tbl%0d_inv", t), n_inv - b_inv, tv[t].e_inv);
         check($sformatf("tbl%0d_hs", t), n_hs - b_hs, tv[t].e_hs);
         check($sformatf("tbl%0d_lat", t), done_cyc - sc, tv[t].e_lat);
         check($sformatf("tbl%0d_busy_end", t), bus.flush_busy, 0);
         check($sformatf("tbl%0d_set_end", t), bus.cur_set, 3);
         check($sformatf("tbl%0d_way_end", t), bus.cur_way, 1);
         cycles(2);
      end

      // Single Owned line at (set 1, way 0)
      load(LS_I);
      mem_st[2]    = LS_O;
      mem_tag[2]   = 20'h5A;
      bus.wb_ready = 1'b1;
      snap();
      start_flush(sc);
      for (int i = 0; i < 40; i++) begin
         if (n_hs != b_hs) break;
         cyc();
      end
      check("one_hs", n_hs - b_hs, 1);
      check("one_addr", last_addr, {20'h5A, 2'd1});
      check("one_inv_same", last_hs_inv, 1);
      check("one_out1", bus.wb_outstanding, 1);
      cycles(30);
      check("one_no_done", n_done - b_done, 0);
      check("one_busy_drain", bus.flush_busy, 1);
      check("one_out_drain", bus.wb_outstanding, 1);
      bus.wb_ack = 1'b1;
      cyc();
      bus.wb_ack = 1'b0;
      check("one_out0", bus.wb_outstanding, 0);
      wait_done("one_done", 5);
      check("one_inv_tot", n_inv - b_inv, 1);
      check("one_uf", bus.ack_underflow, 0);
      cycles(2);

      // All Owned, acks withheld: window fills at 4
      load(LS_O);
      bus.wb_ready = 1'b1;
      snap();
      start_flush(sc);
      cycles(40);
      check("full_hs4", n_hs - b_hs, 4);
      check("full_out4", bus.wb_outstanding, 4);
      check("full_wbv0", bus.wb_valid, 0);
      check("full_busy", bus.flush_busy, 1);
      check("full_set", bus.cur_set, 2);
      check("full_way", bus.cur_way, 0);
      bus.wb_ack = 1'b1;
      cyc();
      bus.wb_ack = 1'b0;
      check("full_out3", bus.wb_outstanding, 3);
      check("full_wbv1", bus.wb_valid, 1);
      check("full_addr5", bus.wb_addr, {20'h104, 2'd2});
      cyc();
      check("full_hs5", n_hs - b_hs, 5);
      check("full_out4b", bus.wb_outstanding, 4);
      acks_until_done("full_done", 300);
      check("full_hs8", n_hs - b_hs, 8);
      check("full_inv8", n_inv - b_inv, 8);
      check("full_out_end", bus.wb_outstanding, 0);
      check("full_uf", bus.ack_underflow, 0);
      cycles(2);

      // wb_ready held low for 5 cycles on Owned line (set 0, way 1)
      load(LS_I);
      mem_st[1]    = LS_O;
      mem_tag[1]   = 20'h3C;
      bus.wb_ready = 1'b0;
      snap();
      start_flush(sc);
      for (int i = 0; i < 20; i++) begin
         if (bus.wb_valid) break;
         cyc();
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_wbv_c%0d", i), bus.wb_valid, 1);
         check($sformatf("bp_addr_c%0d", i), bus.wb_addr, {20'h3C, 2'd0});
         check($sformatf("bp_inv_c%0d", i), bus.inv_en, 0);
         cyc();
      end
      check("bp_no_hs", n_hs - b_hs, 0);
      bus.wb_ready = 1'b1;
      #1;
      check("bp_inv_acc", bus.inv_en, 1);
      cyc();
      check("bp_hs", n_hs - b_hs, 1);
      check("bp_out1", bus.wb_outstanding, 1);
      acks_until_done("bp_done", 60);
      check("bp_inv_tot", n_inv - b_inv, 1);
      cycles(2);

      // Handshake and ack in the same cycle with 2 outstanding
      load(LS_O);
      bus.wb_ready = 1'b1;
      snap();
      start_flush(sc);
      for (int i = 0; i < 60; i++) begin
         if (bus.wb_valid && bus.wb_outstanding == 2) break;
         cyc();
      end
      bus.wb_ack = 1'b1;
      cyc();
      bus.wb_ack = 1'b0;
      check("same_hs3", n_hs - b_hs, 3);
      check("same_out2", bus.wb_outstanding, 2);
      acks_until_done("same_done", 300);
      check("same_uf", bus.ack_underflow, 0);
      cycles(2);

      // Ack in IDLE with nothing outstanding
      check("uf_pre", bus.ack_underflow, 0);
      bus.wb_ack = 1'b1;
      cyc();
      bus.wb_ack = 1'b0;
      check("uf_set", bus.ack_underflow, 1);
      check("uf_out0", bus.wb_outstanding, 0);
      cycles(5);
      check("uf_sticky", bus.ack_underflow, 1);

      // Second flush_start mid-flush is ignored
      load(LS_I);
      snap();
      start_flush(sc);
      cycles(10);
      bus.flush_start = 1'b1;
      cyc();
      bus.flush_start = 1'b0;
      wait_done("restart_done", 40);
      check("restart_lat", done_cyc - sc, LAT);
      check("restart_rd", n_rd - b_rd, 8);
      cycles(5);
      check("restart_ndone", n_done - b_done, 1);
      check("restart_idle", bus.flush_busy, 0);

      // Reset mid-flush with a writeback in flight
      load(LS_I);
      mem_st[0]    = LS_O;
      bus.wb_ready = 1'b1;
      start_flush(sc);
      cycles(8);
      check("mr_out_pre", bus.wb_outstanding, 1);
      check("mr_set_pre", bus.cur_set, 1);
      #3 rst = 1'b0;
      #1;
      check("mr_busy", bus.flush_busy, 0);
      check("mr_set", bus.cur_set, 0);
      check("mr_way", bus.cur_way, 0);
      check("mr_out", bus.wb_outstanding, 0);
      check("mr_uf", bus.ack_underflow, 0);
      check("mr_wbv", bus.wb_valid, 0);
      check("mr_rd_en", bus.tag_rd_en, 0);
      cyc();
      rst = 1'b1;
      cycles(3);
      check("mr_idle", bus.flush_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_flush_seq.md
Name: l2_flush_seq

Overview:
- Sequencer that drives a full L2 flush by walking every set/way in order.
- Reads each line's tag/state from the tag array.
- Issues writebacks for Owned lines and invalidates all valid lines.
- Sits between the L2 input-request arbiter, which raises flush_start, and the tag/state SRAM and LLC request path; it tracks outstanding writebacks so the flush completes only when all are acknowledged.

Parameters:
- L2_SETS, 256, number of sets (power of 2); SET_BITS = log2(L2_SETS)
- L2_WAYS, 8, number of ways (power of 2); WAY_BITS = log2(L2_WAYS)
- TAG_BITS, 20, tag width; writeback address = {tag, set}
- N_WB, 4, max outstanding writebacks; CNT_BITS = log2(N_WB)+1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush_start  in  1  single-cycle flush request
- flush_busy  out  1  high from the cycle after an accepted flush_start until flush_done
- flush_done  out  1  one-cycle completion pulse
- cur_set  out  SET_BITS  set under processing
- cur_way  out  WAY_BITS  way under processing
- tag_rd_en  out  1  tag/state read of (cur_set, cur_way)
- tag_rd_state  in  2  line state, valid the cycle after tag_rd_en
- tag_rd_tag  in  TAG_BITS  line tag, valid the cycle after tag_rd_en
- inv_en  out  1  write state I to (cur_set, cur_way) this cycle
- wb_valid  out  1  writeback request valid
- wb_ready  in  1  writeback request accepted
- wb_addr  out  TAG_BITS+SET_BITS  writeback line address
- wb_ack  in  1  writeback completion from LLC
- wb_outstanding  out  CNT_BITS  writebacks in flight
- ack_underflow  out  1  sticky error flag

Behaviour:
- Reset: FSM = IDLE; cur_set = 0, cur_way = 0, wb_outstanding = 0, ack_underflow = 0; all other outputs 0.
- Line states (shared package): I = 0, V = 1, O = 2, S = 3.
- Combinational outputs: flush_busy = (state != IDLE); tag_rd_en, inv_en, wb_valid and flush_done are decoded from the state.
- IDLE:
  - flush_start -> RD; cur_set and cur_way are cleared to 0.
  - flush_start while not in IDLE is ignored.
- RD: tag_rd_en = 1 -> CHK.
- CHK: register tag_rd_state and tag_rd_tag into st_q and tag_q -> ACT.
- ACT, by st_q:
  - I: advance.
  - V or S: inv_en = 1, then advance.
  - O: wb_valid = 1 only while wb_outstanding < N_WB; wb_addr = {tag_q, cur_set}. When wb_valid && wb_ready, assert inv_en = 1 in the same cycle, then advance. Otherwise hold in ACT with wb_addr stable; wb_valid must not drop once raised until accepted.
- Advance:
  - If cur_way == L2_WAYS-1 and cur_set == L2_SETS-1 -> DRAIN.
  - Else if cur_way == L2_WAYS-1: cur_way = 0, cur_set + 1, -> RD.
  - Else: cur_way + 1, -> RD.
  - Minimum 3 cycles per line.
- DRAIN: wait until wb_outstanding == 0 -> DONE.
- DONE: flush_done = 1 for one cycle -> IDLE; cur_set and cur_way are left at their final values.
- wb_outstanding counter:
  - +1 on a wb handshake, -1 on wb_ack.
  - Both in the same cycle: unchanged.
  - wb_ack with counter 0 and no same-cycle handshake: counter stays 0, ack_underflow is set (sticky until reset).
  - The counter never exceeds N_WB, since wb_valid is gated.
- wb_ack is accepted in any state, including IDLE.
- Reset asserted mid-flush aborts immediately to reset values; no partial-state recovery.
- Counter arithmetic is unsigned; set/way increments never wrap during a flush because the end condition is checked first.

Decomposition:
- Shared package (spandex consts/types): line-state encodings (I/V/O/S), the flush FSM state enum, and SET_BITS/WAY_BITS/CNT_BITS derivations.
- One natural sub-module, l2_flush_wb_cnt: the outstanding up/down counter with saturation guard and underflow flag.
- The FSM and the set/way walker stay in l2_flush_seq.

Test Plan:
- All lines I, L2_SETS=4, L2_WAYS=2 -> 8 reads, no inv_en, no wb_valid; flush_done 3*8+2 = 26 cycles after flush_start.
- Line (set 1, way 0) = O with tag 0x5A, wb_ready always 1 -> one wb with wb_addr = {0x5A, 1}, inv_en in the same cycle; done only after wb_ack; wb_outstanding goes 0->1->0.
- All lines O, N_WB=4, wb_ack withheld -> exactly 4 handshakes, then wb_valid low and FSM held in ACT; one wb_ack -> 5th writeback issues the next cycle.
- wb_ready low for 5 cycles on an O line -> wb_valid and wb_addr stable for all 5 cycles; inv_en only on the accept cycle.
- wb handshake and wb_ack in the same cycle with outstanding = 2 -> stays 2; wb_ack in IDLE with 0 outstanding -> ack_underflow = 1 and stays set.
- flush_start again mid-flush -> ignored; rst pulsed low mid-flush -> flush_busy = 0, cur_set = 0, cur_way = 0, wb_outstanding = 0 immediately.
